emu_mc_doppler_nco: RTL
=======================

# emu_mc_doppler_nco

Parametrised multi-channel complex Doppler NCO for the GPS emulator signal path. It runs NCHAN independent phase accumulators, one per emulated satellite. Each accumulator has a run-time frequency word and phase offset written through a simple config port. All channels advance together on a shared sample strobe and produce signed sin/cos samples from a quarter-wave LUT. It sits between the per-satellite Doppler control logic and the carrier mixers of the GPS synthesizer.

## Interface
Parameters:
- NCHAN, 4: number of independent channels (1..16)
- PHASE_W, 32: accumulator / frequency / offset word width
- LUT_AW, 6: full-cycle phase resolution in bits (≥3); LUT holds 2^(LUT_AW-2) entries
- OUT_W, 6: signed output sample width (≥3)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dv_in  in  1  sample strobe; all channels advance one sample
- sync  in  1  zero all accumulators (phase alignment)
- cfg_we  in  1  config write strobe
- cfg_chan  in  $clog2(NCHAN) (min 1)  target channel
- cfg_freq  in  PHASE_W  phase increment per sample (unsigned, wraps)
- cfg_poff  in  PHASE_W  static phase offset
- dv_out  out  1  output valid
- real_out  out  NCHAN*OUT_W  cos samples, channel c at [c*OUT_W +: OUT_W], two's complement
- imag_out  out  NCHAN*OUT_W  sin samples, same packing

## Operation
- Per channel c: registers freq_c, poff_c, acc_c (PHASE_W bits each).
- Config: when cfg_we=1 and cfg_chan<NCHAN, freq_c and poff_c load at the clock edge. A cfg_chan ≥ NCHAN write is ignored.
- Sample: on a dv_in=1 cycle, the sample phase p_c = acc_c + poff_c (mod 2^PHASE_W) is captured into the pipeline, and acc_c <= acc_c + freq_c.
- A config write in the same cycle as dv_in: that sample uses the old freq/poff. The new values apply from the next dv_in.
- sync=1: all acc_c <= 0.
- sync and dv_in in the same cycle: the sample uses p_c = poff_c (accumulator treated as 0), then acc_c <= freq_c.
- LUT index n = p_c[PHASE_W-1 -: LUT_AW]. Lower phase bits are truncated with no dither.
- Quadrant fold, with Q = 2^(LUT_AW-2), q = n[LUT_AW-1:LUT_AW-2], j = n[LUT_AW-3:0]:
  - T[j] = round((2^(OUT_W-1)-1)·sin(2π(j+0.5)/2^LUT_AW)), unsigned.
  - sin(n): q=0 → T[j]; q=1 → T[Q-1-j]; q=2 → −T[j]; q=3 → −T[Q-1-j].
  - cos(n) = sin(n+Q mod 2^LUT_AW).
- The half-step offset makes the table symmetric. Outputs never reach 0 or −2^(OUT_W-1); the magnitude is ≤ 2^(OUT_W-1)-1.
- Accumulators wrap silently at 2^PHASE_W.

## Timing
- Pipeline, 3 stages, fixed:
  - S1 registers n plus quadrant per channel.
  - S2 registers the LUT read.
  - S3 registers the conditional negate and drives the outputs.
- Latency: dv_in at edge k gives dv_out=1 and its samples valid after edge k+3. dv_out is a 1-cycle pulse per dv_in.
- Back-to-back dv_in gives back-to-back dv_out. dv_in gaps propagate unchanged.
- real_out/imag_out hold their last values while dv_out=0.
- Reset values: acc, freq and poff are 0 for all channels. dv_out=0, real_out=0, imag_out=0. All pipeline valid bits are cleared.
- Reset mid-operation discards in-flight samples. No dv_out appears for samples in flight at reset.
- No backpressure. The downstream block must accept every dv_out.

## Structure
- Package emu_nco_pkg holds:
  - default parameter constants;
  - a function computing the channel select width;
  - a function producing the quarter-wave table T for given LUT_AW/OUT_W, used in elaboration-time initialisation.
- Sub-module emu_nco_sincos_lut implements stages S1–S3 for one channel: phase in, cos/sin out, fixed 3-cycle latency. It is instantiated NCHAN times with a generate loop.
- The top level holds the config registers, the accumulators, sync handling and valid pipeline.

## Test plan
Defaults PHASE_W=32, LUT_AW=6, OUT_W=6, so amplitude is 31.
- Reset then idle → dv_out=0, all outputs 0. Then dv_in pulses with freq=0, poff=0 → every channel gives real=31, imag=2, exactly 3 cycles after each pulse.
- ch0 freq=0x4000_0000, 4 consecutive dv_in → (real,imag) = (31,2), (−2,31), (−31,−2), (2,−31), then repeats. dv_out is high for 4 cycles.
- ch1 poff=0x8000_0000, freq=0 → (−31,−2) constant. Other channels keep (31,2), confirming channel independence.
- cfg write ch0 freq=0x4000_0000 in the same cycle as dv_in → that sample is (31,2), and the next sample is also (31,2) because the old freq=0 was used. The following sample is (−2,31).
- After 3 samples at freq=0x4000_0000, assert sync with dv_in → that sample is (31,2) and the next is (−2,31). Also: freq=0xFFFF_FFFF wraps to n=63 on the first step → (31,−2).
- cfg_we with cfg_chan=NCHAN (NCHAN=3 build) → no channel changes. Reset asserted with 2 samples in flight → no dv_out afterward.

Source files
------------

// File: rtl/emu_nco_pkg.sv
// emu_nco_pkg: defaults and elaboration-time helpers
// for the multi-channel Doppler NCO.
package emu_nco_pkg;

    localparam int NCO_NCHAN_DEF   = 4;
    localparam int NCO_PHASE_W_DEF = 32;
    localparam int NCO_LUT_AW_DEF  = 6;
    localparam int NCO_OUT_W_DEF   = 6;

    // pi in Q30 fixed point
    localparam longint NCO_PI_Q30 = 64'sd3373259426;

    function automatic int nco_chan_w(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

    // Taylor series, x in Q30 radians within [0, pi/2]
    function automatic longint nco_sin_q30(input longint x);
        longint x2;
        longint term;
        longint acc;
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int k = 1; k < 10; k++) begin
            term = -(((term * x2) >>> 30) /
                     longint'((2 * k) * (2 * k + 1)));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Quarter-wave entry T[j], half-step offset, rounded
    function automatic int nco_tab_entry(
        input int j,
        input int lut_aw,
        input int out_w
    );
        longint theta;
        longint amp;
        longint s;
        theta = (NCO_PI_Q30 * longint'(2 * j + 1)) >>> lut_aw;
        amp   = (longint'(1) <<< (out_w - 1)) - 1;
        s     = nco_sin_q30(theta);
        return int'((amp * s + (longint'(1) <<< 29)) >>> 30);
    endfunction

endpackage

// File: rtl/emu_nco_sincos_lut.sv
// emu_nco_sincos_lut: one channel's phase-to-cos/sin path,
// quadrant fold, quarter-wave read and negate over 3 stages.
module emu_nco_sincos_lut
    import emu_nco_pkg::*;
#(
    parameter int PHASE_W = NCO_PHASE_W_DEF,
    parameter int LUT_AW  = NCO_LUT_AW_DEF,
    parameter int OUT_W   = NCO_OUT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_ld,
    input  logic [PHASE_W-1:0] i_phase,
    output logic [OUT_W-1:0]   o_cos,
    output logic [OUT_W-1:0]   o_sin
);

    localparam int QW = LUT_AW - 2;
    localparam int QN = 2 ** QW;
    localparam int TW = OUT_W - 1;

    logic [TW-1:0] w_tab [QN];

    for (genvar j = 0; j < QN; j++) begin : g_tab
        assign w_tab[j] = TW'(nco_tab_entry(j, LUT_AW, OUT_W));
    end

    logic [LUT_AW-1:0] w_n_s;
    logic [LUT_AW-1:0] w_n_c;
    logic              w_unused_lsb;

    assign w_n_s = i_phase[PHASE_W-1 -: LUT_AW];
    assign w_n_c = w_n_s + LUT_AW'(QN);
    assign w_unused_lsb = ^i_phase[PHASE_W-LUT_AW-1:0];

    logic [QW-1:0] r_s_idx;
    logic [QW-1:0] r_c_idx;
    logic          r_s_neg1;
    logic          r_c_neg1;

    // Odd quadrants read the table mirrored: Q-1-j == ~j
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_idx  <= '0;
            r_c_idx  <= '0;
            r_s_neg1 <= 1'b0;
            r_c_neg1 <= 1'b0;
        end else begin
            r_s_idx  <= w_n_s[LUT_AW-2] ? ~w_n_s[QW-1:0]
                                        :  w_n_s[QW-1:0];
            r_c_idx  <= w_n_c[LUT_AW-2] ? ~w_n_c[QW-1:0]
                                        :  w_n_c[QW-1:0];
            r_s_neg1 <= w_n_s[LUT_AW-1];
            r_c_neg1 <= w_n_c[LUT_AW-1];
        end
    end

    logic [TW-1:0] r_s_mag;
    logic [TW-1:0] r_c_mag;
    logic          r_s_neg2;
    logic          r_c_neg2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_mag  <= '0;
            r_c_mag  <= '0;
            r_s_neg2 <= 1'b0;
            r_c_neg2 <= 1'b0;
        end else begin
            r_s_mag  <= w_tab[r_s_idx];
            r_c_mag  <= w_tab[r_c_idx];
            r_s_neg2 <= r_s_neg1;
            r_c_neg2 <= r_c_neg1;
        end
    end

    logic [OUT_W-1:0] r_sin;
    logic [OUT_W-1:0] r_cos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sin <= '0;
            r_cos <= '0;
        end else if (i_ld) begin
            r_sin <= r_s_neg2 ? -{1'b0, r_s_mag} : {1'b0, r_s_mag};
            r_cos <= r_c_neg2 ? -{1'b0, r_c_mag} : {1'b0, r_c_mag};
        end
    end

    assign o_sin = r_sin;
    assign o_cos = r_cos;

endmodule

// File: rtl/emu_mc_doppler_nco.sv
// emu_mc_doppler_nco: NCHAN phase accumulators with per-channel
// frequency/offset config, shared sample strobe and sync.
module emu_mc_doppler_nco
    import emu_nco_pkg::*;
#(
    parameter int NCHAN   = NCO_NCHAN_DEF,
    parameter int PHASE_W = NCO_PHASE_W_DEF,
    parameter int LUT_AW  = NCO_LUT_AW_DEF,
    parameter int OUT_W   = NCO_OUT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dv_in,
    input  logic                         sync,
    input  logic                         cfg_we,
    input  logic [nco_chan_w(NCHAN)-1:0] cfg_chan,
    input  logic [PHASE_W-1:0]           cfg_freq,
    input  logic [PHASE_W-1:0]           cfg_poff,
    output logic                         dv_out,
    output logic [NCHAN*OUT_W-1:0]       real_out,
    output logic [NCHAN*OUT_W-1:0]       imag_out
);

    localparam int CW = nco_chan_w(NCHAN);

    logic [PHASE_W-1:0] r_freq  [NCHAN];
    logic [PHASE_W-1:0] r_poff  [NCHAN];
    logic [PHASE_W-1:0] r_acc   [NCHAN];
    logic [PHASE_W-1:0] r_phase [NCHAN];
    logic [PHASE_W-1:0] w_base  [NCHAN];
    logic [PHASE_W-1:0] w_phase [NCHAN];
    logic               w_cfg_ok;
    logic [2:0]         r_vld;
    logic               r_dv_out;

    assign w_cfg_ok = cfg_we && (32'(cfg_chan) < 32'(NCHAN));

    // sync makes the accumulator read as zero for this cycle
    always_comb begin
        for (int c = 0; c < NCHAN; c++) begin
            w_base[c]  = sync ? '0 : r_acc[c];
            w_phase[c] = w_base[c] + r_poff[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_acc[c]   <= '0;
                r_freq[c]  <= '0;
                r_poff[c]  <= '0;
                r_phase[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (dv_in) begin
                    r_acc[c]   <= w_base[c] + r_freq[c];
                    r_phase[c] <= w_phase[c];
                end else if (sync) begin
                    r_acc[c] <= '0;
                end
                if (w_cfg_ok && cfg_chan == CW'(c)) begin
                    r_freq[c] <= cfg_freq;
                    r_poff[c] <= cfg_poff;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld    <= '0;
            r_dv_out <= 1'b0;
        end else begin
            r_vld    <= {r_vld[1:0], dv_in};
            r_dv_out <= r_vld[2];
        end
    end

    assign dv_out = r_dv_out;

    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        emu_nco_sincos_lut #(
            .PHASE_W (PHASE_W),
            .LUT_AW  (LUT_AW),
            .OUT_W   (OUT_W)
        ) u_lut (
            .clk     (clk),
            .reset   (reset),
            .i_ld    (r_vld[2]),
            .i_phase (r_phase[c]),
            .o_cos   (real_out[c*OUT_W +: OUT_W]),
            .o_sin   (imag_out[c*OUT_W +: OUT_W])
        );
    end

endmodule
